rst_seq_gen: RTL and testbench

Parametrised reset sequencer for the FPGA system top. It replaces the fixed vendor reset IP between the MMCM and the e203 SoC. It merges the board reset, auxiliary reset, MMCM lock and debug reset requests, filters the pad-level inputs, and enforces a minimum reset hold time. It then releases N_OUT active-high reset outputs in staged order (interconnect first, peripherals/core last) and records the cause of the last reset.

---
 rtl/rst_seq_gen.sv | 167 ++++++++++++++++
 tb/tb_rst_seq_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: merges board, aux, MMCM-lock and debug reset requests,
// enforces a hold time, then releases N_OUT resets in order and records the cause.
module rst_seq_gen #(
  parameter int N_OUT       = 3,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_rst_n,
  input  logic             aux_rst,
  input  logic             locked,
  input  logic             dbg_rst,
  output logic [N_OUT-1:0] rst_out,
  output logic             busy,
  output logic [3:0]       cause
);

  localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_HG > DEB_CYCLES) ? MAX_HG : DEB_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;
  localparam int STG_W  = $clog2(N_OUT) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [STG_W-1:0] STG_LAST  = STG_W'(N_OUT - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  logic [1:0] ext_sync, aux_sync, lock_sync;
  logic [CNT_W-1:0] ext_cnt, aux_cnt;
  logic ext_v, aux_v;

  // Locked syncs to 0 so the sequence waits for a real lock after rst.
  // NOTE: every clocked register below uses non-blocking assignment so all
  // flops sample pre-edge values, exactly like the hardware they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync  <= 2'b11;
      aux_sync  <= 2'b00;
      lock_sync <= 2'b00;
    end else begin
      ext_sync  <= {ext_sync[0], ext_rst_n};
      aux_sync  <= {aux_sync[0], aux_rst};
      lock_sync <= {lock_sync[0], locked};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_cnt <= '0;
      ext_v   <= 1'b0;
    end else if (ext_sync[1]) begin
      ext_cnt <= '0;
      ext_v   <= 1'b0;
    end else if (ext_cnt == DEB_LAST) begin
      ext_v   <= 1'b1;
    end else begin
      ext_cnt <= ext_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_cnt <= '0;
      aux_v   <= 1'b0;
    end else if (!aux_sync[1]) begin
      aux_cnt <= '0;
      aux_v   <= 1'b0;
    end else if (aux_cnt == DEB_LAST) begin
      aux_v   <= 1'b1;
    end else begin
      aux_cnt <= aux_cnt + CNT_ONE;
    end
  end

  logic [3:0] req_bits;
  logic       req;
  assign req_bits = {dbg_rst, aux_v, ext_v, ~lock_sync[1]};
  assign req      = |req_bits;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [STG_W-1:0] stage, stage_n;
  logic [N_OUT-1:0] rst_out_n;
  logic [3:0]       cause_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      stage   <= '0;
      rst_out <= '1;
      cause   <= 4'b0000;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      stage   <= stage_n;
      rst_out <= rst_out_n;
      cause   <= cause_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stage_n   = stage;
    rst_out_n = rst_out;
    cause_n   = cause;
    case (state)
      HOLD: begin
        if (req) begin
          cnt_n   = '0;
          cause_n = cause | req_bits;
        end else if (cnt == HOLD_LAST) begin
          rst_out_n[0] = 1'b0;
          cnt_n        = '0;
          stage_n      = STG_W'(1);
          state_n      = (N_OUT == 1) ? RUN : RELEASE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      RELEASE: begin
        if (req) begin
          rst_out_n = '1;
          cnt_n     = '0;
          stage_n   = '0;
          state_n   = HOLD;
          cause_n   = req_bits;
        end else if (cnt == GAP_LAST) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (STG_W'(i) == stage) rst_out_n[i] = 1'b0;
          end
          cnt_n   = '0;
          stage_n = stage + STG_W'(1);
          if (stage == STG_LAST) state_n = RUN;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (req) begin
          rst_out_n = '1;
          cnt_n     = '0;
          stage_n   = '0;
          state_n   = HOLD;
          cause_n   = req_bits;
        end
      end
      default: begin
        rst_out_n = '1;
        cnt_n     = '0;
        stage_n   = '0;
        state_n   = HOLD;
      end
    endcase
  end

  assign busy = (state != RUN);

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: default instance plus two small-parameter
// instances; expected outputs are queued with the edge at which they must hold.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ext_rst_n, aux_rst, locked, dbg_rst;

  logic [2:0] rst_out0; logic busy0; logic [3:0] cause0;
  logic [0:0] rst_out1; logic busy1; logic [3:0] cause1;
  logic [4:0] rst_out2; logic busy2; logic [3:0] cause2;

  rst_seq_gen dut (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .aux_rst(aux_rst),
    .locked(locked), .dbg_rst(dbg_rst),
    .rst_out(rst_out0), .busy(busy0), .cause(cause0)
  );

  rst_seq_gen #(.N_OUT(1), .DEB_CYCLES(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_min (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .aux_rst(aux_rst),
    .locked(locked), .dbg_rst(dbg_rst),
    .rst_out(rst_out1), .busy(busy1), .cause(cause1)
  );

  rst_seq_gen #(.N_OUT(5), .DEB_CYCLES(1), .HOLD_CYCLES(1), .STAGE_GAP(3)) dut_five (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .aux_rst(aux_rst),
    .locked(locked), .dbg_rst(dbg_rst),
    .rst_out(rst_out2), .busy(busy2), .cause(cause2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    int         at;
    logic [4:0] rst_out;
    logic       busy;
    logic [3:0] cause;
    bit         chk_cause;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void expect_at(input int d, input int at, input logic [4:0] r,
                                    input logic b, input logic [3:0] c, input bit cc);
    exp_t e;
    e.dut = d; e.at = at; e.rst_out = r; e.busy = b; e.cause = c; e.chk_cause = cc;
    sb.push_back(e);
  endfunction

  exp_t       mon_e;
  logic [4:0] mon_r;
  logic       mon_b;
  logic [3:0] mon_c;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.dut)
        0:       begin mon_r = {2'b00, rst_out0};   mon_b = busy0; mon_c = cause0; end
        1:       begin mon_r = {4'b0000, rst_out1}; mon_b = busy1; mon_c = cause1; end
        default: begin mon_r = rst_out2;            mon_b = busy2; mon_c = cause2; end
      endcase
      n_tests++;
      if (mon_e.at != cyc) begin
        n_fail++;
        $display("FAIL sb_missed dut%0d: expectation for edge %0d reached at edge %0d",
                 mon_e.dut, mon_e.at, cyc);
      end else if (mon_r !== mon_e.rst_out || mon_b !== mon_e.busy ||
                   (mon_e.chk_cause && mon_c !== mon_e.cause)) begin
        n_fail++;
        $display("FAIL sb_dut%0d@%0d: got rst_out=%b busy=%b cause=%b, want rst_out=%b busy=%b cause=%b%s",
                 mon_e.dut, cyc, mon_r, mon_b, mon_c, mon_e.rst_out, mon_e.busy, mon_e.cause,
                 mon_e.chk_cause ? "" : " (cause not checked)");
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d expectations pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_rst_n = 1'b1; aux_rst = 1'b0; locked = 1'b1; dbg_rst = 1'b0;
    #1;
    n_tests++;
    if (rst_out0 !== 3'b111 || busy0 !== 1'b1 || cause0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut0: got %b/%b/%b, want 111/1/0000", rst_out0, busy0, cause0);
    end
    n_tests++;
    if (rst_out1 !== 1'b1 || busy1 !== 1'b1 || cause1 !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b/%b/%b, want 1/1/0000", rst_out1, busy1, cause1);
    end
    n_tests++;
    if (rst_out2 !== 5'b11111 || busy2 !== 1'b1 || cause2 !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dut2: got %b/%b/%b, want 11111/1/0000", rst_out2, busy2, cause2);
    end
    repeat (3) @(negedge clk);
  endtask

  // The two sync edges of the locked input make the last request edge k = 2.
  task automatic test_power_on();
    int t;
    @(negedge clk);
    t = cyc;
    rst = 1'b0;
    expect_at(0, t + 65, 5'b00111, 1'b1, 4'b0, 1'b0);
    expect_at(0, t + 66, 5'b00110, 1'b1, 4'b0, 1'b0);
    expect_at(0, t + 73, 5'b00110, 1'b1, 4'b0, 1'b0);
    expect_at(0, t + 74, 5'b00100, 1'b1, 4'b0, 1'b0);
    expect_at(0, t + 81, 5'b00100, 1'b1, 4'b0, 1'b0);
    expect_at(0, t + 82, 5'b00000, 1'b0, 4'b0, 1'b0);
    wait_drain("power_on");
  endtask

  task automatic test_ext_filter();
    int t, r;
    @(negedge clk);
    t = cyc;
    ext_rst_n = 1'b0;
    expect_at(0, t + 5,  5'b00000, 1'b0, 4'b0, 1'b0);
    expect_at(0, t + 15, 5'b00000, 1'b0, 4'b0, 1'b0);
    expect_at(0, t + 25, 5'b00000, 1'b0, 4'b0, 1'b0);
    repeat (10) @(negedge clk);
    ext_rst_n = 1'b1;
    wait_drain("ext_short");

    @(negedge clk);
    t = cyc;
    ext_rst_n = 1'b0;
    expect_at(0, t + 18, 5'b00000, 1'b0, 4'b0000, 1'b0);
    expect_at(0, t + 19, 5'b00111, 1'b1, 4'b0010, 1'b1);
    repeat (20) @(negedge clk);
    ext_rst_n = 1'b1;
    r = cyc;
    // Filter clears on the third edge after the pin rise, so k = r + 3.
    expect_at(0, r + 66, 5'b00111, 1'b1, 4'b0010, 1'b1);
    expect_at(0, r + 67, 5'b00110, 1'b1, 4'b0010, 1'b1);
    expect_at(0, r + 74, 5'b00110, 1'b1, 4'b0010, 1'b0);
    expect_at(0, r + 75, 5'b00100, 1'b1, 4'b0010, 1'b0);
    expect_at(0, r + 82, 5'b00100, 1'b1, 4'b0010, 1'b0);
    expect_at(0, r + 83, 5'b00000, 1'b0, 4'b0010, 1'b1);
    wait_drain("ext_long");
  endtask

  task automatic test_lock();
    int t;
    @(negedge clk);
    t = cyc;
    locked = 1'b0;
    expect_at(0, t + 2,  5'b00000, 1'b0, 4'b0000, 1'b0);
    expect_at(0, t + 3,  5'b00111, 1'b1, 4'b0001, 1'b1);
    expect_at(0, t + 66, 5'b00111, 1'b1, 4'b0001, 1'b0);
    expect_at(0, t + 67, 5'b00110, 1'b1, 4'b0001, 1'b0);
    expect_at(0, t + 75, 5'b00100, 1'b1, 4'b0001, 1'b0);
    expect_at(0, t + 83, 5'b00000, 1'b0, 4'b0001, 1'b1);
    @(negedge clk);
    locked = 1'b1;
    wait_drain("lock");
  endtask

  task automatic test_dbg_mid_release();
    int t, f;
    @(negedge clk);
    t = cyc;
    f = t + 65;
    dbg_rst = 1'b1;
    expect_at(0, t + 1,  5'b00111, 1'b1, 4'b1000, 1'b1);
    expect_at(0, f - 1,  5'b00111, 1'b1, 4'b1000, 1'b0);
    expect_at(0, f,      5'b00110, 1'b1, 4'b1000, 1'b0);
    expect_at(0, f + 1,  5'b00110, 1'b1, 4'b1000, 1'b0);
    expect_at(0, f + 2,  5'b00111, 1'b1, 4'b1000, 1'b1);
    expect_at(0, f + 65, 5'b00111, 1'b1, 4'b1000, 1'b0);
    expect_at(0, f + 66, 5'b00110, 1'b1, 4'b1000, 1'b1);
    @(negedge clk);
    dbg_rst = 1'b0;
    for (int n = 0; n < 200 && cyc < f + 1; n++) @(negedge clk);
    dbg_rst = 1'b1;
    @(negedge clk);
    dbg_rst = 1'b0;
    wait_drain("dbg");
  endtask

  task automatic test_simultaneous();
    int g;
    @(negedge clk);
    g = cyc + 1;
    dbg_rst = 1'b1;
    expect_at(0, g,      5'b00111, 1'b1, 4'b1000, 1'b1);
    expect_at(0, g + 3,  5'b00111, 1'b1, 4'b1000, 1'b1);
    expect_at(0, g + 4,  5'b00111, 1'b1, 4'b1001, 1'b1);
    expect_at(0, g + 67, 5'b00111, 1'b1, 4'b1001, 1'b0);
    expect_at(0, g + 68, 5'b00110, 1'b1, 4'b1001, 1'b1);
    expect_at(0, g + 70, 5'b00110, 1'b1, 4'b1001, 1'b0);
    @(negedge clk);
    dbg_rst = 1'b0;
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    @(negedge clk);
    dbg_rst = 1'b1;
    @(negedge clk);
    dbg_rst = 1'b0;
    wait_drain("simultaneous");

    @(posedge clk);
    #2;
    n_tests++;
    if (rst_out0 !== 3'b110) begin
      n_fail++;
      $display("FAIL pre_async_rst: got rst_out=%b, want 110", rst_out0);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (rst_out0 !== 3'b111 || busy0 !== 1'b1 || cause0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_rst: got %b/%b/%b, want 111/1/0000", rst_out0, busy0, cause0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_param_sweep();
    int t;
    @(negedge clk);
    t = cyc;
    rst = 1'b0;
    expect_at(1, t + 2,  5'b00001, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 2,  5'b11111, 1'b1, 4'b0, 1'b0);
    expect_at(1, t + 3,  5'b00000, 1'b0, 4'b0, 1'b0);
    expect_at(2, t + 3,  5'b11110, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 5,  5'b11110, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 6,  5'b11100, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 9,  5'b11000, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 12, 5'b10000, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 14, 5'b10000, 1'b1, 4'b0, 1'b0);
    expect_at(2, t + 15, 5'b00000, 1'b0, 4'b0, 1'b0);
    wait_drain("sweep_power_on");

    @(negedge clk);
    t = cyc;
    dbg_rst = 1'b1;
    expect_at(1, t + 1, 5'b00001, 1'b1, 4'b1000, 1'b1);
    expect_at(1, t + 2, 5'b00000, 1'b0, 4'b1000, 1'b1);
    @(negedge clk);
    dbg_rst = 1'b0;
    wait_drain("sweep_dbg");

    // One-cycle pulses are accepted when the debounce length is 1.
    @(negedge clk);
    t = cyc;
    ext_rst_n = 1'b0;
    expect_at(1, t + 3, 5'b00000, 1'b0, 4'b1000, 1'b0);
    expect_at(1, t + 4, 5'b00001, 1'b1, 4'b0010, 1'b1);
    expect_at(1, t + 5, 5'b00000, 1'b0, 4'b0010, 1'b1);
    @(negedge clk);
    ext_rst_n = 1'b1;
    wait_drain("sweep_ext");

    @(negedge clk);
    t = cyc;
    aux_rst = 1'b1;
    expect_at(1, t + 3, 5'b00000, 1'b0, 4'b0010, 1'b0);
    expect_at(1, t + 4, 5'b00001, 1'b1, 4'b0100, 1'b1);
    expect_at(1, t + 5, 5'b00000, 1'b0, 4'b0100, 1'b1);
    @(negedge clk);
    aux_rst = 1'b0;
    wait_drain("sweep_aux");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_on();
    test_ext_filter();
    test_lock();
    test_dbg_mid_release();
    test_simultaneous();
    test_param_sweep();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
